video_capture: RTL and testbench

- Decoder for the Spectrum-style video generator. Consumes its pixel-rate RGBI + hsync/vsync stream and rebuilds a 6912-byte Spectrum-format screen image: 6144 bitmap bytes plus 768 attribute bytes.
- Writes the image into a 13-bit-addressed screen RAM. Used for loopback verification and frame grabbing.
- Also recovers the border colour and counts colour-clash cells.

---
 rtl/video_capture.sv | 187 ++++++++++++++++++
 tb/tb_video_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// Rebuilds a Spectrum-format screen image (bitmap + attributes) from a pixel-rate
// RGBI/hsync/vsync stream, and recovers border colour and colour-clash statistics.
module video_capture #(
    parameter int H_OFFSET = 117,
    parameter int V_OFFSET = 64,
    parameter int V_ACTIVE = 192
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        r,
    input  logic        g,
    input  logic        b,
    input  logic        i,
    output logic        we,
    output logic [12:0] a,
    output logic [7:0]  q,
    output logic [2:0]  border,
    output logic        locked,
    output logic        frameDone,
    output logic [7:0]  clashCount
);

    localparam logic [8:0] X_START  = 9'(H_OFFSET);
    localparam logic [8:0] X_END    = 9'(H_OFFSET + 255);
    localparam logic [8:0] X_BORDER = 9'(H_OFFSET - 16);
    localparam logic [8:0] V_START  = 9'(V_OFFSET);
    localparam logic [8:0] V_END    = 9'(V_OFFSET + V_ACTIVE);
    localparam logic [7:0] Y_LAST   = 8'(V_ACTIVE - 1);

    logic        hs_q, vs_q;
    logic [8:0]  x_q, line_q;
    logic [3:0]  paper, ink;
    logic        ink_set, clash;
    logic [7:0]  bits;
    logic [31:0] attr_valid;
    logic        attr_pending;
    logic [12:0] attr_a;
    logic [7:0]  attr_q;
    logic [7:0]  clash_cnt;
    logic [1:0]  done_pipe;

    logic        hs_rise, vs_rise;
    logic [8:0]  x_cur, line_next;
    logic [2:0]  next_row_line;
    logic [7:0]  y, rel;
    logic [4:0]  col;
    logic [2:0]  pos;
    logic [3:0]  colour;
    logic        line_active, pix_active, cell_done, need_attr;
    logic [3:0]  paper_n, ink_n;
    logic        ink_set_n, clash_n;
    logic [7:0]  bits_n;

    assign hs_rise = ce & hsync & ~hs_q;
    assign vs_rise = ce & vsync & ~vs_q;
    assign colour  = {i, g, r, b};

    // The pixel sampled on a ce sees the x value after that ce's update, so the
    // hsync-rise tick itself is x = 0.
    assign x_cur = hs_rise ? 9'd0 : (x_q == 9'h1FF ? x_q : x_q + 9'd1);

    // A coincident vsync rise wins: the line restarts at 0 without the hsync increment.
    assign line_next     = vs_rise ? 9'd0 :
                           (hs_rise && line_q != 9'h1FF) ? line_q + 9'd1 : line_q;
    assign next_row_line = 3'(line_next - V_START);

    assign y           = 8'(line_q - V_START);
    assign rel         = 8'(x_cur - X_START);
    assign col         = rel[7:3];
    assign pos         = rel[2:0];
    assign line_active = (line_q >= V_START) && (line_q < V_END);
    assign pix_active  = ce && locked && line_active && (x_cur >= X_START) && (x_cur <= X_END);
    assign cell_done   = pix_active && (pos == 3'd7);

    // NOTE: every output gets its default first, so this block cannot infer a latch.
    always_comb begin
        paper_n   = paper;
        ink_n     = ink;
        ink_set_n = ink_set;
        clash_n   = clash;
        bits_n    = bits;
        if (pos == 3'd0) begin
            paper_n   = colour;
            ink_n     = colour;
            ink_set_n = 1'b0;
            clash_n   = 1'b0;
            bits_n    = 8'h00;
        end else if (colour != paper) begin
            bits_n = bits | (8'h80 >> pos);
            if (!ink_set) begin
                ink_n     = colour;
                ink_set_n = 1'b1;
            end else if (colour != ink) begin
                clash_n = 1'b1;
            end
        end
    end

    assign need_attr = !attr_valid[col] && (ink_set_n || (y[2:0] == 3'd7));

    // NOTE: all state here is registered with non-blocking assignments; attr_valid is a
    // flag vector rather than a RAM, so resetting it is cheap and keeps rows independent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            x_q          <= '0;
            line_q       <= '0;
            paper        <= '0;
            ink          <= '0;
            ink_set      <= 1'b0;
            clash        <= 1'b0;
            bits         <= '0;
            attr_valid   <= '0;
            attr_pending <= 1'b0;
            attr_a       <= '0;
            attr_q       <= '0;
            clash_cnt    <= '0;
            done_pipe    <= '0;
            we           <= 1'b0;
            a            <= '0;
            q            <= '0;
            border       <= '0;
            locked       <= 1'b0;
            frameDone    <= 1'b0;
            clashCount   <= '0;
        end else begin
            we        <= 1'b0;
            frameDone <= done_pipe[0];
            done_pipe <= {1'b0, done_pipe[1]};

            if (attr_pending) begin
                we           <= 1'b1;
                a            <= attr_a;
                q            <= attr_q;
                attr_pending <= 1'b0;
            end

            if (ce) begin
                hs_q   <= hsync;
                vs_q   <= vsync;
                x_q    <= x_cur;
                line_q <= line_next;

                if (vs_rise) begin
                    locked     <= 1'b1;
                    clashCount <= clash_cnt;
                end
                if ((vs_rise || hs_rise) && next_row_line == 3'd0)
                    attr_valid <= '0;
                if (x_cur == X_BORDER)
                    border <= {g, r, b};

                if (pix_active) begin
                    paper   <= paper_n;
                    ink     <= ink_n;
                    ink_set <= ink_set_n;
                    clash   <= clash_n;
                    bits    <= bits_n;
                end

                if (cell_done) begin
                    we           <= 1'b1;
                    a            <= {y[7:6], y[2:0], y[5:3], col};
                    q            <= bits_n;
                    attr_pending <= need_attr;
                    attr_a       <= {3'b110, y[7:6], y[5:3], col};
                    attr_q       <= {1'b0, paper_n, ink_n[2:0]};
                    if (ink_set_n && !attr_valid[col])
                        attr_valid[col] <= 1'b1;
                    if (y == Y_LAST && col == 5'd31)
                        done_pipe <= need_attr ? 2'b10 : 2'b01;
                end

                // Cleared on vsync rise; a clash finishing on that same ce is dropped.
                if (vs_rise)
                    clash_cnt <= '0;
                else if (cell_done && clash_n && clash_cnt != 8'hFF)
                    clash_cnt <= clash_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture: stimulus pushes the expected RAM writes,
// a negedge monitor pops and compares them whenever we is high.
module tb_video_capture;

    localparam int H_OFF  = 20;
    localparam int V_OFF  = 4;
    localparam int LINE_T = H_OFF + 256 + 4;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  q;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce, hsync, vsync, r, g, b, i;
    logic        we;
    logic [12:0] a;
    logic [7:0]  q;
    logic [2:0]  border;
    logic        locked, frameDone;
    logic [7:0]  clashCount;

    int   checks   = 0;
    int   failures = 0;
    int   done_pulses = 0;
    int   wr_idx   = 0;
    wr_t  sb[$];
    wr_t  mon_e;
    logic prev_we = 1'b0;
    logic [12:0] prev_a = '0;
    bit   valid_model[32];

    video_capture #(.H_OFFSET(H_OFF), .V_OFFSET(V_OFF), .V_ACTIVE(192)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .i(i), .we(we), .a(a), .q(q), .border(border),
        .locked(locked), .frameDone(frameDone), .clashCount(clashCount)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Hand-drawn image. mode 2 fills lines 0..9 with three-colour cells.
    function automatic logic [3:0] pix(input int mode, input int y, input int xr);
        int c = xr / 8;
        int p = xr % 8;
        if (mode == 2) return (y < 10) ? ((p == 1) ? 4'd4 : (p == 2) ? 4'd1 : 4'd2) : 4'd0;
        if (y == 0 && c == 0)          return (p % 2 == 1) ? 4'd14 : 4'd9;
        if (y >= 8 && y <= 15 && c == 5) return 4'd7;
        if (y == 50)                   return (p < 4) ? 4'd1 : 4'd6;
        if (y == 100 && c == 31)       return (p == 1) ? 4'd4 : (p == 2) ? 4'd1 : 4'd2;
        return 4'd0;
    endfunction

    // Hand-computed bitmap/attribute bytes for each cell of the image above.
    task automatic cell_exp(input int mode, input int y, input int c,
                            output logic [7:0] bm, output logic [7:0] at, output bit two);
        bm = 8'h00; at = 8'h00; two = 1'b0;
        if (mode == 2) begin
            if (y < 10) begin bm = 8'h60; at = 8'h14; two = 1'b1; end
        end else if (y == 0 && c == 0) begin
            bm = 8'h55; at = 8'h4E; two = 1'b1;
        end else if (y >= 8 && y <= 15 && c == 5) begin
            at = 8'h3F;
        end else if (y == 50) begin
            bm = 8'h0F; at = 8'h0E; two = 1'b1;
        end else if (y == 100 && c == 31) begin
            bm = 8'h60; at = 8'h14; two = 1'b1;
        end
    endtask

    task automatic push_line(input int mode, input int y, input int ncols);
        logic [7:0] bm, at;
        bit two;
        wr_t e;
        if (y % 8 == 0) foreach (valid_model[k]) valid_model[k] = 1'b0;
        for (int c = 0; c < ncols; c++) begin
            cell_exp(mode, y, c, bm, at, two);
            e.a = 13'((y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + c);
            e.q = bm;
            sb.push_back(e);
            if (!valid_model[c] && (two || y % 8 == 7)) begin
                e.a = 13'(13'h1800 + (y / 64) * 256 + ((y / 8) % 8) * 32 + c);
                e.q = at;
                sb.push_back(e);
                if (two) valid_model[c] = 1'b1;
            end
        end
    endtask

    task automatic drive_line(input int mode, input int ln, input int div, input int nticks);
        int y = ln - V_OFF;
        logic [3:0] c;
        for (int k = 0; k < nticks; k++) begin
            @(posedge clock); #1;
            ce    = 1'b1;
            hsync = (k < 4);
            vsync = (ln == 0);
            if (y >= 0 && y < 192 && k >= H_OFF && k < H_OFF + 256) c = pix(mode, y, k - H_OFF);
            else c = (mode == 2) ? 4'd5 : 4'd2;
            {i, g, r, b} = c;
            if (div == 2) begin
                @(posedge clock); #1;
                ce = 1'b0;
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (we) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write a=0x%0h q=0x%0h", a, q);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("wr_addr#%0d", wr_idx), 32'(a), 32'(mon_e.a));
                    check($sformatf("wr_data#%0d@%0h", wr_idx, mon_e.a), 32'(q), 32'(mon_e.q));
                    wr_idx++;
                end
            end
            if (frameDone) begin
                done_pulses++;
                check("frame_done_after_last_write", {18'd0, prev_we, prev_a}, {18'd0, 1'b1, 13'h1AFF});
            end
            prev_we = we;
            prev_a  = a;
        end
    end

    initial begin
        reset_n = 1'b0;
        ce = 1'b0; hsync = 1'b0; vsync = 1'b0; {i, g, r, b} = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_we", 32'(we), 0);
        check("reset_a", 32'(a), 0);
        check("reset_q", 32'(q), 0);
        check("reset_border", 32'(border), 0);
        check("reset_locked", 32'(locked), 0);
        check("reset_frame_done", 32'(frameDone), 0);
        check("reset_clash_count", 32'(clashCount), 0);
        reset_n = 1'b1;

        // Frame 0: lines y=0,1 written, then reset hits mid-line y=2.
        for (int ln = 0; ln < V_OFF + 2; ln++) begin
            if (ln >= V_OFF) push_line(0, ln - V_OFF, 32);
            drive_line(0, ln, 1, LINE_T);
        end
        push_line(0, 2, 10);
        drive_line(0, V_OFF + 2, 1, H_OFF + 83);
        @(posedge clock); #1;
        ce = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("we_in_reset", 32'(we), 0);
        check("locked_in_reset", 32'(locked), 0);
        reset_n = 1'b1;
        drive_line(0, 5, 1, LINE_T);
        drive_line(0, 6, 1, LINE_T);
        check("locked_before_vsync", 32'(locked), 0);

        // Frame 1: full frame, ce every clock.
        for (int ln = 0; ln < V_OFF + 192; ln++) begin
            if (ln >= V_OFF) push_line(1, ln - V_OFF, 32);
            drive_line(1, ln, 1, LINE_T);
            if (ln == 0) begin
                check("locked_after_vsync", 32'(locked), 1);
                check("clash_count_frame0", 32'(clashCount), 0);
            end
        end
        check("border_red", 32'(border), 32'b010);

        // Frame 2: 320 clash cells, ce every other clock.
        for (int ln = 0; ln < V_OFF + 10; ln++) begin
            if (ln >= V_OFF) push_line(2, ln - V_OFF, 32);
            drive_line(2, ln, 2, LINE_T);
            if (ln == 0) check("clash_count_one", 32'(clashCount), 1);
        end
        check("border_cyan", 32'(border), 32'b101);

        drive_line(2, 0, 1, LINE_T);
        check("clash_count_saturated", 32'(clashCount), 255);

        ce = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 0);
        check("frame_done_pulses", 32'(done_pulses), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
